// File: rtl/rotator_pkg.sv
// Shared defaults and FSM state encoding for the rotator family.
package rotator_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AMT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } rot_state_t;

endpackage

// File: rtl/left_rotate_step.sv
// Combinational single-bit left rotate: the MSB wraps around into bit 0.
module left_rotate_step #(
  parameter int WIDTH = rotator_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] word_in,
  output logic [WIDTH-1:0] word_out
);

  assign word_out = {word_in[WIDTH-2:0], word_in[WIDTH-1]};

endmodule

// File: rtl/seq_left_rotator.sv
// Sequential left rotator: captures a word and an amount on start, rotates
// one bit per clock, and publishes the result with a one-cycle done pulse.
module seq_left_rotator
  import rotator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] d_in,
  input  logic [AMT_W-1:0] bit_amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d_out
);

  rot_state_t       state;
  rot_state_t       state_next;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_rot;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] result;
  logic             take;
  logic             shift;
  logic             last_step;

  left_rotate_step #(.WIDTH(WIDTH)) u_step (
    .word_in  (work),
    .word_out (work_rot)
  );

  // cnt counts remaining rotations; at 1 the step output is the final result.
  assign last_step = (cnt == AMT_W'(1));

  // State register; reset clears it immediately without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a new request is accepted in IDLE and in DONE.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    shift      = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          take       = 1'b1;
          state_next = (bit_amount == '0) ? DONE : ROTATE;
        end else begin
          state_next = IDLE;
        end
      end
      ROTATE: begin
        shift = 1'b1;
        if (last_step) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Working register and counter: load on accept, rotate and count down after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
    end else if (take) begin
      work <= d_in;
      cnt  <= bit_amount;
    end else if (shift) begin
      work <= work_rot;
      cnt  <= cnt - AMT_W'(1);
    end
  end

  // Result register: written only on entry to DONE so it holds steady otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if (take && (bit_amount == '0)) begin
      result <= d_in;
    end else if (shift && last_step) begin
      result <= work_rot;
    end
  end

  // Status outputs decode straight from the state.
  always_comb begin
    busy  = (state == ROTATE);
    done  = (state == DONE);
    d_out = result;
  end

endmodule

// File: tb/tb_seq_left_rotator.sv
// Self-checking bench for seq_left_rotator using an expected-result queue.
module tb_seq_left_rotator;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] d_in;
  logic [AMT_W-1:0] bit_amount;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] exp_q[$];

  seq_left_rotator #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .d_in       (d_in),
    .bit_amount (bit_amount),
    .busy       (busy),
    .done       (done),
    .d_out      (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference right rotator, used as an independent model for left rotation.
  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int r);
    logic [2*WIDTH-1:0] dbl;
    dbl = {x, x} >> r;
    return dbl[WIDTH-1:0];
  endfunction

  // Drive one request at the next edge (edge E); leaves time at E+1.
  task automatic issue(input logic [WIDTH-1:0] d, input int amt);
    start      = 1'b1;
    d_in       = d;
    bit_amount = AMT_W'(amt);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen (bounded).
  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++;
    if (d_out !== 8'h00) begin n_err++; $display("FAIL reset_dout got=%h exp=00", d_out); end
    $display("reset: busy=%b done=%b d_out=%h", busy, done, d_out);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sweep;
    logic [WIDTH-1:0] table_v [8];
    logic [WIDTH-1:0] e;
    int edges;
    table_v[0] = 8'b10010010; table_v[1] = 8'b00100101;
    table_v[2] = 8'b01001010; table_v[3] = 8'b10010100;
    table_v[4] = 8'b00101001; table_v[5] = 8'b01010010;
    table_v[6] = 8'b10100100; table_v[7] = 8'b01001001;
    for (int n = 0; n < 8; n++) begin
      exp_q.push_back(table_v[n]);
      issue(8'b10010010, n);
      wait_done(edges);
      n_cmp++;
      if (edges !== n) begin n_err++; $display("FAIL sweep_latency amt=%0d got=%0d exp=%0d", n, edges, n); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if (d_out !== e) begin n_err++; $display("FAIL sweep_dout amt=%0d got=%b exp=%b", n, d_out, e); end
      $display("sweep: amt=%0d d_out=%b edges=%0d", n, d_out, edges);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_cross;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] e;
    int k;
    int edges;
    for (int i = 0; i < 20; i++) begin
      d = WIDTH'($urandom);
      k = $urandom_range(0, 7);
      exp_q.push_back(rotr(d, (8 - k) % 8));
      issue(d, k);
      wait_done(edges);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_cmp++;
      if (d_out !== e) begin n_err++; $display("FAIL cross d_in=%h k=%0d got=%h exp=%h", d, k, d_out, e); end
      $display("cross: d_in=%h k=%0d d_out=%h", d, k, d_out);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_busy_ignore;
    int busy_cycles = 0;
    int done_cycles = 0;
    logic [WIDTH-1:0] e;
    exp_q.push_back(8'h1E);
    issue(8'hF0, 5);
    for (int c = 0; c < 12; c++) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_cycles++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        n_cmp++;
        if (d_out !== e) begin n_err++; $display("FAIL busy_ignore_dout got=%h exp=%h", d_out, e); end
      end
      if (c == 1) begin
        start = 1'b1; d_in = 8'h0F; bit_amount = 3'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (busy_cycles !== 5) begin n_err++; $display("FAIL busy_ignore_busy got=%0d exp=5", busy_cycles); end
    n_cmp++;
    if (done_cycles !== 1) begin n_err++; $display("FAIL busy_ignore_done got=%0d exp=1", done_cycles); end
    $display("busy_ignore: busy_cycles=%0d done_cycles=%0d d_out=%h", busy_cycles, done_cycles, d_out);
  endtask

  task automatic test_back_to_back;
    int edges;
    logic [WIDTH-1:0] e;
    exp_q.push_back(8'h06);
    issue(8'h81, 2);
    wait_done(edges);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_cmp++;
    if (d_out !== e) begin n_err++; $display("FAIL b2b_first got=%h exp=%h", d_out, e); end
    exp_q.push_back(8'h06);
    issue(8'h06, 0);
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done2 got=%b exp=1", done); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_cmp++;
    if (d_out !== e) begin n_err++; $display("FAIL b2b_second got=%h exp=%h", d_out, e); end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_drop got=%b exp=0", done); end
    $display("back_to_back: d_out=%h", d_out);
  endtask

  task automatic test_async_reset;
    int edges;
    logic [WIDTH-1:0] e;
    exp_q.push_back(8'hAA);
    issue(8'hAA, 6);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL areset_busy got=%b exp=0", busy); end
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL areset_done got=%b exp=0", done); end
    n_cmp++;
    if (d_out !== 8'h00) begin n_err++; $display("FAIL areset_dout got=%h exp=00", d_out); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL areset_idle got=%b%b exp=00", busy, done); end
    exp_q.push_back(8'h08);
    issue(8'h01, 3);
    wait_done(edges);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_cmp++;
    if (d_out !== e) begin n_err++; $display("FAIL areset_after got=%h exp=%h", d_out, e); end
    $display("async_reset: post-release d_out=%h edges=%0d", d_out, edges);
    @(posedge clk);
    #1;
  endtask

  task automatic test_hold;
    int edges;
    logic [WIDTH-1:0] e;
    exp_q.push_back(8'h25);
    issue(8'h52, 4);
    wait_done(edges);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    n_cmp++;
    if (d_out !== e) begin n_err++; $display("FAIL hold_result got=%h exp=%h", d_out, e); end
    @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      d_in       = WIDTH'($urandom);
      bit_amount = AMT_W'($urandom);
      @(posedge clk);
      #1;
      n_cmp++;
      if (d_out !== 8'h25) begin n_err++; $display("FAIL hold_dout cyc=%0d got=%h exp=25", c, d_out); end
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL hold_done cyc=%0d got=%b exp=0", c, done); end
    end
    $display("hold: d_out=%h after 10 idle cycles", d_out);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    d_in       = '0;
    bit_amount = '0;
    #12;
    test_reset();
    test_sweep();
    test_cross();
    test_busy_ignore();
    test_back_to_back();
    test_async_reset();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
